jtag_tap_param: RTL and testbench
=================================

JTAG_TAP_PARAM -- requirements
Module: jtag_tap_param

Interface
REQ-001 Parameter IR_W, default 4: instruction register width, SHALL be >= 2.
REQ-002 Parameter BSR_W, default 8: boundary-scan register width, SHALL be >= 1.
REQ-003 Parameter IDCODE, default 32'h1000_0001: device ID; bit 0 SHALL be 1, elaboration error otherwise.
REQ-004 Parameter SYNC_STAGES, default 2: synchronizer depth for tck/tms/tdi, SHALL be >= 2.
REQ-005 clk  in  1  single system clock; all state SHALL change on posedge clk only.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 tck  in  1  JTAG test clock, asynchronous to clk, oversampled as data.
REQ-008 tms  in  1  JTAG mode select, asynchronous.
REQ-009 tdi  in  1  JTAG serial data in, asynchronous.
REQ-010 tdo  out  1  JTAG serial data out.
REQ-011 tdo_oe  out  1  tdo output enable.
REQ-012 bsr_capture  in  BSR_W  parallel pin/core values captured into BSR.
REQ-013 bsr_update  out  BSR_W  BSR update (hold) register.
REQ-014 bsr_update_stb  out  1  one-clk pulse when bsr_update is loaded.
REQ-015 extest_o  out  1  high while active instruction is EXTEST.
REQ-016 intest_o  out  1  high while active instruction is INTEST.
REQ-017 state_o  out  4  current TAP state code (REQ-021).
REQ-018 ir_o  out  IR_W  active (updated) instruction.

Function
REQ-019 tck, tms, tdi SHALL each pass through SYNC_STAGES flops; tck_rise/tck_fall SHALL be one-clk pulses on synchronized tck 0->1 / 1->0, tms/tdi sampled from their synchronized copies in the same cycle.
REQ-020 Correct operation SHALL require tck high and low phases each >= SYNC_STAGES+2 clk periods; tck edge to internal action latency SHALL be SYNC_STAGES+1 clk cycles.
REQ-021 State codes: 0 TLR, 1 RTI, 2 SEL_DR, 3 CAP_DR, 4 SH_DR, 5 EX1_DR, 6 PAU_DR, 7 EX2_DR, 8 UPD_DR, 9 SEL_IR, 10 CAP_IR, 11 SH_IR, 12 EX1_IR, 13 PAU_IR, 14 EX2_IR, 15 UPD_IR.
REQ-022 FSM SHALL advance only on tck_rise, using IEEE 1149.1 transitions; SEL_IR with tms=1 -> TLR; 5 consecutive tms=1 rises from any state SHALL reach TLR.
REQ-023 Instructions: all-zeros EXTEST, 1 IDCODE, 2 SAMPLE_PRELOAD, 3 INTEST, all-ones BYPASS; any other code SHALL select BYPASS register.
REQ-024 On tck_rise in CAP_IR: IR shift <= {0..0,2'b01}; in SH_IR: shift right, tdi into MSB.
REQ-025 On tck_fall in UPD_IR: ir_o <= IR shift. In TLR (any tck edge or entry): ir_o <= IDCODE instruction.
REQ-026 DR selection by ir_o: BYPASS 1 bit, IDCODE 32 bit, EXTEST/INTEST/SAMPLE_PRELOAD BSR_W bit.
REQ-027 On tck_rise in CAP_DR: BYPASS <= 0; IDCODE reg <= IDCODE; BSR <= bsr_capture. In SH_DR: selected DR shifts right, tdi into MSB; unselected DRs hold.
REQ-028 On tck_fall in UPD_DR with BSR selected: bsr_update <= BSR shift, bsr_update_stb = 1 for exactly that clk.
REQ-029 On tck_fall: if state is SH_IR or SH_DR, tdo <= LSB of active shift register and tdo_oe <= 1; else tdo_oe <= 0, tdo holds.
REQ-030 extest_o/intest_o SHALL be combinational decodes of ir_o, forced 0 when state is TLR.
REQ-031 tck_rise and tck_fall never both assert; edges seen while rst=1 SHALL be discarded, no pending edge after release.

Reset
REQ-032 While rst=1 at posedge clk: state_o=0 (TLR), ir_o=IDCODE instruction (1), IR/BSR/bypass shift = 0, IDCODE reg = IDCODE, bsr_update=0, bsr_update_stb=0, tdo=0, tdo_oe=0, extest_o=intest_o=0.
REQ-033 Synchronizer/edge-history flops SHALL keep sampling during rst so release does not generate a false edge.
REQ-034 rst mid-shift SHALL abort without any update of ir_o or bsr_update.

Verification
REQ-035 Reset, then 5 tck with tms=1 from state SH_DR -> state_o=0, ir_o=1, tdo_oe=0.
REQ-036 TLR->RTI->SH_DR, shift 32 bits with default IR -> tdo stream 0x1000_0001 LSB first, tdo_oe=1 only during shift.
REQ-037 Load IR=4'b1111, shift DR 8 bits pattern 0xA5 -> tdo equals tdi delayed by one tck (bypass).
REQ-038 IR=0 (EXTEST), bsr_capture=0x3C, shift in 0xC3 -> tdo out 0x3C LSB first; UPD_DR -> bsr_update=0xC3, single stb pulse, extest_o=1.
REQ-039 Shift IR with tms/tdi changing and rst asserted mid-shift -> all outputs per REQ-032, ir_o stays 1.
REQ-040 IR=4'b0101 (undefined) -> DR behaves as 1-bit bypass; CAP_IR shift yields tdo 1 then 0.

Source files
------------

// File: rtl/jtag_tap_param.sv
// JTAG TAP controller oversampled on one system clock.
// tck/tms/tdi are synchronized as data; every flop moves on posedge clk.
module jtag_tap_param #(
    parameter int          IR_W        = 4,
    parameter int          BSR_W       = 8,
    parameter logic [31:0] IDCODE      = 32'h1000_0001,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tck,
    input  logic             tms,
    input  logic             tdi,
    output logic             tdo,
    output logic             tdo_oe,
    input  logic [BSR_W-1:0] bsr_capture,
    output logic [BSR_W-1:0] bsr_update,
    output logic             bsr_update_stb,
    output logic             extest_o,
    output logic             intest_o,
    output logic [3:0]       state_o,
    output logic [IR_W-1:0]  ir_o
);

    if (IR_W < 2) begin : g_chk_ir
        $error("IR_W must be >= 2");
    end
    if (BSR_W < 1) begin : g_chk_bsr
        $error("BSR_W must be >= 1");
    end
    if (IDCODE[0] != 1'b1) begin : g_chk_idcode
        $error("IDCODE bit 0 must be 1");
    end
    if (SYNC_STAGES < 2) begin : g_chk_sync
        $error("SYNC_STAGES must be >= 2");
    end

    typedef enum logic [3:0] {
        TLR    = 4'd0,  RTI    = 4'd1,  SEL_DR = 4'd2,  CAP_DR = 4'd3,
        SH_DR  = 4'd4,  EX1_DR = 4'd5,  PAU_DR = 4'd6,  EX2_DR = 4'd7,
        UPD_DR = 4'd8,  SEL_IR = 4'd9,  CAP_IR = 4'd10, SH_IR  = 4'd11,
        EX1_IR = 4'd12, PAU_IR = 4'd13, EX2_IR = 4'd14, UPD_IR = 4'd15
    } tap_state_e;

    localparam logic [IR_W-1:0] IR_EXTEST  = '0;
    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(1);
    localparam logic [IR_W-1:0] IR_SAMPLE  = IR_W'(2);
    localparam logic [IR_W-1:0] IR_INTEST  = IR_W'(3);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(1);

    logic [SYNC_STAGES-1:0] tck_sync_q, tck_sync_d;
    logic [SYNC_STAGES-1:0] tms_sync_q, tms_sync_d;
    logic [SYNC_STAGES-1:0] tdi_sync_q, tdi_sync_d;
    logic                   tck_prev_q, tck_prev_d;

    tap_state_e       state_q, state_d;
    logic [IR_W-1:0]  ir_q, ir_d;
    logic [IR_W-1:0]  ir_sh_q, ir_sh_d;
    logic [BSR_W-1:0] bsr_sh_q, bsr_sh_d;
    logic [BSR_W-1:0] bsr_upd_q, bsr_upd_d;
    logic [31:0]      idcode_sh_q, idcode_sh_d;
    logic             bypass_q, bypass_d;
    logic             stb_q, stb_d;
    logic             tdo_q, tdo_d;
    logic             oe_q, oe_d;

    logic tck_s, tms_s, tdi_s;
    logic tck_rise, tck_fall;
    logic bsr_sel, idc_sel, dr_lsb;

    assign tck_s = tck_sync_q[SYNC_STAGES-1];
    assign tms_s = tms_sync_q[SYNC_STAGES-1];
    assign tdi_s = tdi_sync_q[SYNC_STAGES-1];

    // Edges are masked during rst; the history flops still track tck.
    assign tck_rise = tck_s & ~tck_prev_q & ~rst;
    assign tck_fall = ~tck_s & tck_prev_q & ~rst;

    assign bsr_sel = (ir_q == IR_EXTEST) || (ir_q == IR_SAMPLE) ||
                     (ir_q == IR_INTEST);
    assign idc_sel = (ir_q == IR_IDCODE);
    assign dr_lsb  = bsr_sel ? bsr_sh_q[0] :
                     idc_sel ? idcode_sh_q[0] : bypass_q;

    always_comb begin
        tck_sync_d = {tck_sync_q[SYNC_STAGES-2:0], tck};
        tms_sync_d = {tms_sync_q[SYNC_STAGES-2:0], tms};
        tdi_sync_d = {tdi_sync_q[SYNC_STAGES-2:0], tdi};
        tck_prev_d = tck_s;
    end

    always_ff @(posedge clk) begin
        tck_sync_q <= tck_sync_d;
        tms_sync_q <= tms_sync_d;
        tdi_sync_q <= tdi_sync_d;
        tck_prev_q <= tck_prev_d;
    end

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        ir_sh_d     = ir_sh_q;
        bsr_sh_d    = bsr_sh_q;
        bsr_upd_d   = bsr_upd_q;
        idcode_sh_d = idcode_sh_q;
        bypass_d    = bypass_q;
        stb_d       = 1'b0;
        tdo_d       = tdo_q;
        oe_d        = oe_q;

        if (tck_rise) begin
            unique case (state_q)
                TLR:    state_d = tms_s ? TLR    : RTI;
                RTI:    state_d = tms_s ? SEL_DR : RTI;
                SEL_DR: state_d = tms_s ? SEL_IR : CAP_DR;
                CAP_DR: state_d = tms_s ? EX1_DR : SH_DR;
                SH_DR:  state_d = tms_s ? EX1_DR : SH_DR;
                EX1_DR: state_d = tms_s ? UPD_DR : PAU_DR;
                PAU_DR: state_d = tms_s ? EX2_DR : PAU_DR;
                EX2_DR: state_d = tms_s ? UPD_DR : SH_DR;
                UPD_DR: state_d = tms_s ? SEL_DR : RTI;
                SEL_IR: state_d = tms_s ? TLR    : CAP_IR;
                CAP_IR: state_d = tms_s ? EX1_IR : SH_IR;
                SH_IR:  state_d = tms_s ? EX1_IR : SH_IR;
                EX1_IR: state_d = tms_s ? UPD_IR : PAU_IR;
                PAU_IR: state_d = tms_s ? EX2_IR : PAU_IR;
                EX2_IR: state_d = tms_s ? UPD_IR : SH_IR;
                UPD_IR: state_d = tms_s ? SEL_DR : RTI;
            endcase

            if (state_q == CAP_IR) begin
                ir_sh_d = IR_CAPTURE;
            end
            if (state_q == SH_IR) begin
                ir_sh_d = ir_sh_q >> 1;
                ir_sh_d[IR_W-1] = tdi_s;
            end
            if (state_q == CAP_DR) begin
                if (bsr_sel)      bsr_sh_d    = bsr_capture;
                else if (idc_sel) idcode_sh_d = IDCODE;
                else              bypass_d    = 1'b0;
            end
            if (state_q == SH_DR) begin
                if (bsr_sel) begin
                    bsr_sh_d = bsr_sh_q >> 1;
                    bsr_sh_d[BSR_W-1] = tdi_s;
                end else if (idc_sel) begin
                    idcode_sh_d = idcode_sh_q >> 1;
                    idcode_sh_d[31] = tdi_s;
                end else begin
                    bypass_d = tdi_s;
                end
            end
        end

        if (tck_fall) begin
            if (state_q == UPD_IR) begin
                ir_d = ir_sh_q;
            end
            if (state_q == UPD_DR && bsr_sel) begin
                bsr_upd_d = bsr_sh_q;
                stb_d     = 1'b1;
            end
            if (state_q == SH_IR || state_q == SH_DR) begin
                tdo_d = (state_q == SH_IR) ? ir_sh_q[0] : dr_lsb;
                oe_d  = 1'b1;
            end else begin
                oe_d  = 1'b0;
            end
        end

        if (state_q == TLR) begin
            ir_d = IR_IDCODE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= TLR;
            ir_q        <= IR_IDCODE;
            ir_sh_q     <= '0;
            bsr_sh_q    <= '0;
            bsr_upd_q   <= '0;
            idcode_sh_q <= IDCODE;
            bypass_q    <= 1'b0;
            stb_q       <= 1'b0;
            tdo_q       <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            ir_q        <= ir_d;
            ir_sh_q     <= ir_sh_d;
            bsr_sh_q    <= bsr_sh_d;
            bsr_upd_q   <= bsr_upd_d;
            idcode_sh_q <= idcode_sh_d;
            bypass_q    <= bypass_d;
            stb_q       <= stb_d;
            tdo_q       <= tdo_d;
            oe_q        <= oe_d;
        end
    end

    assign tdo            = tdo_q;
    assign tdo_oe         = oe_q;
    assign bsr_update     = bsr_upd_q;
    assign bsr_update_stb = stb_q;
    assign state_o        = state_q;
    assign ir_o           = ir_q;
    assign extest_o       = (state_q != TLR) && (ir_q == IR_EXTEST);
    assign intest_o       = (state_q != TLR) && (ir_q == IR_INTEST);

endmodule

// File: tb/tb_jtag_tap_param.sv
// Bench for jtag_tap_param: drives slow tck against clk and checks
// tdo streams through a queue of expected bits.
module tb_jtag_tap_param;

    localparam int IR_W  = 4;
    localparam int BSR_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             tck;
    logic             tms;
    logic             tdi;
    logic             tdo;
    logic             tdo_oe;
    logic [BSR_W-1:0] bsr_capture;
    logic [BSR_W-1:0] bsr_update;
    logic             bsr_update_stb;
    logic             extest_o;
    logic             intest_o;
    logic [3:0]       state_o;
    logic [IR_W-1:0]  ir_o;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    logic exp_q[$];
    logic [31:0] idc_v = 32'h1000_0001;

    jtag_tap_param #(
        .IR_W(IR_W), .BSR_W(BSR_W),
        .IDCODE(32'h1000_0001), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi),
        .tdo(tdo), .tdo_oe(tdo_oe),
        .bsr_capture(bsr_capture), .bsr_update(bsr_update),
        .bsr_update_stb(bsr_update_stb),
        .extest_o(extest_o), .intest_o(intest_o),
        .state_o(state_o), .ir_o(ir_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bsr_update_stb) stb_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: run did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic tck_cycle(input logic m, input logic d,
                             output logic o, output logic e);
        tms = m;
        tdi = d;
        wait_clk(6);
        tck = 1'b1;
        wait_clk(6);
        tck = 1'b0;
        wait_clk(6);
        o = tdo;
        e = tdo_oe;
    endtask

    task automatic step(input logic m);
        logic o, e;
        tck_cycle(m, 1'b0, o, e);
    endtask

    task automatic goto_tlr();
        repeat (5) step(1'b1);
    endtask

    // From RTI: load IR, return the captured bits seen on tdo, end in RTI.
    task automatic load_ir(input logic [IR_W-1:0] v,
                           output logic [IR_W-1:0] cap);
        logic o, e;
        cap = '0;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        tck_cycle(1'b0, 1'b0, o, e);
        cap[0] = o;
        for (int i = 0; i < IR_W; i++) begin
            tck_cycle(i == IR_W - 1, v[i], o, e);
            if (i < IR_W - 1) cap[i+1] = o;
        end
        step(1'b1);
        step(1'b0);
    endtask

    // From RTI: shift n DR bits, pass UPD_DR, end in RTI.
    task automatic shift_dr(input int n, input logic [31:0] din,
                            output logic [31:0] dout,
                            output logic [32:0] oe_seen);
        logic o, e;
        dout = '0;
        oe_seen = '0;
        step(1'b1);
        step(1'b0);
        tck_cycle(1'b0, 1'b0, o, e);
        dout[0] = o;
        oe_seen[0] = e;
        for (int i = 0; i < n; i++) begin
            tck_cycle(i == n - 1, din[i], o, e);
            if (i < n - 1) dout[i+1] = o;
            oe_seen[i+1] = e;
        end
        step(1'b1);
        step(1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tck = 1'b0;
        tms = 1'b0;
        tdi = 1'b0;
        bsr_capture = '0;
        wait_clk(10);
        tck = 1'b1;
        wait_clk(10);
        rst = 1'b0;
        wait_clk(12);
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", state_o);
        end
        checks++;
        if (ir_o !== 4'd1) begin
            errors++;
            $display("FAIL reset_ir: got %0h expected 1", ir_o);
        end
        checks++;
        if ({tdo, tdo_oe, bsr_update_stb} !== 3'b000) begin
            errors++;
            $display("FAIL reset_tdo: tdo/oe/stb got %b expected 000",
                     {tdo, tdo_oe, bsr_update_stb});
        end
        checks++;
        if (bsr_update !== 8'h00) begin
            errors++;
            $display("FAIL reset_upd: got %h expected 00", bsr_update);
        end
        checks++;
        if ({extest_o, intest_o} !== 2'b00) begin
            errors++;
            $display("FAIL reset_test_modes: got %b expected 00",
                     {extest_o, intest_o});
        end
        tck = 1'b0;
        wait_clk(12);
    endtask

    task automatic test_tlr_from_shdr();
        step(1'b0);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        checks++;
        if (state_o !== 4'd4 || tdo_oe !== 1'b1) begin
            errors++;
            $display("FAIL enter_sh_dr: state %0d oe %b expected 4 1",
                     state_o, tdo_oe);
        end
        goto_tlr();
        checks++;
        if (state_o !== 4'd0 || ir_o !== 4'd1 || tdo_oe !== 1'b0) begin
            errors++;
            $display("FAIL tms5_to_tlr: state %0d ir %0h oe %b expected 0 1 0",
                     state_o, ir_o, tdo_oe);
        end
    endtask

    task automatic test_idcode();
        logic [31:0] din, dout;
        logic [32:0] oe_seen;
        logic exp;
        step(1'b0);
        checks++;
        if (state_o !== 4'd1) begin
            errors++;
            $display("FAIL enter_rti: got %0d expected 1", state_o);
        end
        din = $urandom();
        for (int i = 0; i < 32; i++) exp_q.push_back(idc_v[i]);
        shift_dr(32, din, dout, oe_seen);
        for (int i = 0; i < 32; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (dout[i] !== exp) begin
                errors++;
                $display("FAIL idcode_bit%0d: got %b expected %b",
                         i, dout[i], exp);
            end
        end
        checks++;
        if (oe_seen !== 33'h0_FFFF_FFFF) begin
            errors++;
            $display("FAIL idcode_oe: got %h expected 0ffffffff", oe_seen);
        end
    endtask

    task automatic test_bypass();
        logic [IR_W-1:0] cap;
        logic [31:0] din, dout;
        logic [32:0] oe_seen;
        logic exp;
        load_ir(4'hF, cap);
        checks++;
        if (ir_o !== 4'hF || cap !== 4'b0001) begin
            errors++;
            $display("FAIL bypass_ir: ir %h cap %b expected f 0001", ir_o, cap);
        end
        din = 32'hA5;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) exp_q.push_back(din[i]);
        shift_dr(8, din, dout, oe_seen);
        for (int i = 0; i < 8; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (dout[i] !== exp) begin
                errors++;
                $display("FAIL bypass_bit%0d: got %b expected %b",
                         i, dout[i], exp);
            end
        end
        checks++;
        if (oe_seen !== 33'h0_0000_00FF) begin
            errors++;
            $display("FAIL bypass_oe: got %h expected 0000000ff", oe_seen);
        end
    endtask

    task automatic test_intest();
        logic [IR_W-1:0] cap;
        load_ir(4'h3, cap);
        checks++;
        if (intest_o !== 1'b1 || extest_o !== 1'b0) begin
            errors++;
            $display("FAIL intest_on: intest %b extest %b expected 1 0",
                     intest_o, extest_o);
        end
        goto_tlr();
        checks++;
        if (intest_o !== 1'b0 || ir_o !== 4'd1) begin
            errors++;
            $display("FAIL intest_tlr: intest %b ir %h expected 0 1",
                     intest_o, ir_o);
        end
        step(1'b0);
    endtask

    task automatic test_back_to_back();
        logic [IR_W-1:0] cap;
        logic [31:0] din, dout;
        logic [32:0] oe_seen;
        logic [BSR_W-1:0] exp_w;
        int s0;
        load_ir(4'h2, cap);
        s0 = stb_cnt;
        for (int k = 0; k < 2; k++) begin
            bsr_capture = 8'($urandom());
            din = 32'($urandom_range(255, 0));
            for (int i = 0; i < BSR_W; i++) exp_q.push_back(bsr_capture[i]);
            shift_dr(BSR_W, din, dout, oe_seen);
            for (int i = 0; i < BSR_W; i++) exp_w[i] = exp_q.pop_front();
            checks++;
            if (dout[BSR_W-1:0] !== exp_w) begin
                errors++;
                $display("FAIL sample_out%0d: got %h expected %h",
                         k, dout[BSR_W-1:0], exp_w);
            end
            checks++;
            if (bsr_update !== din[BSR_W-1:0]) begin
                errors++;
                $display("FAIL sample_upd%0d: got %h expected %h",
                         k, bsr_update, din[BSR_W-1:0]);
            end
        end
        checks++;
        if (stb_cnt - s0 !== 2) begin
            errors++;
            $display("FAIL sample_stb: got %0d pulses expected 2", stb_cnt - s0);
        end
    endtask

    task automatic test_extest();
        logic [IR_W-1:0] cap;
        logic [31:0] dout;
        logic [32:0] oe_seen;
        logic exp;
        int s0;
        bsr_capture = 8'h3C;
        load_ir(4'h0, cap);
        checks++;
        if (extest_o !== 1'b1 || intest_o !== 1'b0) begin
            errors++;
            $display("FAIL extest_on: extest %b intest %b expected 1 0",
                     extest_o, intest_o);
        end
        s0 = stb_cnt;
        for (int i = 0; i < BSR_W; i++) exp_q.push_back(bsr_capture[i]);
        shift_dr(BSR_W, 32'hC3, dout, oe_seen);
        for (int i = 0; i < BSR_W; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (dout[i] !== exp) begin
                errors++;
                $display("FAIL extest_bit%0d: got %b expected %b",
                         i, dout[i], exp);
            end
        end
        checks++;
        if (bsr_update !== 8'hC3 || stb_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL extest_upd: upd %h stb %0d expected c3 1",
                     bsr_update, stb_cnt - s0);
        end
        checks++;
        if (extest_o !== 1'b1) begin
            errors++;
            $display("FAIL extest_hold: got %b expected 1", extest_o);
        end
    endtask

    task automatic test_rst_mid_shift();
        logic o, e;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        tck_cycle(1'b0, 1'b1, o, e);
        tck_cycle(1'b0, 1'b1, o, e);
        tck_cycle(1'b0, 1'b0, o, e);
        checks++;
        if (state_o !== 4'd11 || e !== 1'b1) begin
            errors++;
            $display("FAIL mid_sh_ir: state %0d oe %b expected 11 1",
                     state_o, e);
        end
        tms = 1'b1;
        tdi = 1'b1;
        wait_clk(3);
        tck = 1'b1;
        rst = 1'b1;
        wait_clk(8);
        checks++;
        if (state_o !== 4'd0 || ir_o !== 4'd1) begin
            errors++;
            $display("FAIL rst_mid_state: state %0d ir %h expected 0 1",
                     state_o, ir_o);
        end
        checks++;
        if ({tdo, tdo_oe, bsr_update_stb, extest_o, intest_o} !== 5'b0 ||
            bsr_update !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_outs: tdo/oe/stb/ext/int %b upd %h expected 00000 00",
                     {tdo, tdo_oe, bsr_update_stb, extest_o, intest_o},
                     bsr_update);
        end
        tck = 1'b0;
        wait_clk(8);
        rst = 1'b0;
        wait_clk(8);
        step(1'b1);
        step(1'b1);
        checks++;
        if (state_o !== 4'd0 || ir_o !== 4'd1 || bsr_update !== 8'h00) begin
            errors++;
            $display("FAIL rst_release: state %0d ir %h upd %h expected 0 1 00",
                     state_o, ir_o, bsr_update);
        end
    endtask

    task automatic test_undef_ir();
        logic [IR_W-1:0] cap;
        logic [31:0] din, dout;
        logic [32:0] oe_seen;
        logic [BSR_W-1:0] upd0;
        logic exp;
        int s0;
        step(1'b0);
        load_ir(4'h5, cap);
        checks++;
        if (cap !== 4'b0001) begin
            errors++;
            $display("FAIL undef_cap: got %b expected 0001", cap);
        end
        checks++;
        if (ir_o !== 4'h5 || {extest_o, intest_o} !== 2'b00) begin
            errors++;
            $display("FAIL undef_ir: ir %h ext/int %b expected 5 00",
                     ir_o, {extest_o, intest_o});
        end
        s0 = stb_cnt;
        upd0 = bsr_update;
        din = $urandom();
        exp_q.push_back(1'b0);
        for (int i = 0; i < 7; i++) exp_q.push_back(din[i]);
        shift_dr(8, din, dout, oe_seen);
        for (int i = 0; i < 8; i++) begin
            exp = exp_q.pop_front();
            checks++;
            if (dout[i] !== exp) begin
                errors++;
                $display("FAIL undef_bit%0d: got %b expected %b",
                         i, dout[i], exp);
            end
        end
        checks++;
        if (bsr_update !== upd0 || stb_cnt - s0 !== 0) begin
            errors++;
            $display("FAIL undef_no_upd: upd %h stb %0d expected %h 0",
                     bsr_update, stb_cnt - s0, upd0);
        end
    endtask

    initial begin
        test_reset();
        test_tlr_from_shdr();
        test_idcode();
        test_bypass();
        test_intest();
        test_back_to_back();
        test_extest();
        test_rst_mid_shift();
        test_undef_ir();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
